// File: rtl/vga_scan_renderer_pkg.sv
// Shared definitions for the display path: the category codes the game core
// returns for each pixel, the colour each category is drawn in, and the
// default 640x480@60 Hz timing for a 100 MHz system clock.
package vga_scan_renderer_pkg;

    typedef enum logic [3:0] {
        CAT_NONE   = 4'd0,
        CAT_WALL   = 4'd1,
        CAT_TANK   = 4'd2,
        CAT_BULLET = 4'd3
    } category_e;

    localparam logic [11:0] RGB_BLACK  = 12'h000;
    localparam logic [11:0] RGB_WALL   = 12'h888;
    localparam logic [11:0] RGB_TANK   = 12'h0F0;
    localparam logic [11:0] RGB_BULLET = 12'hF00;

    localparam int VGA_CLK_DIV  = 4;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Unknown codes draw as black so a corrupted category never lights a pixel.
    function automatic logic [11:0] category_colour(input logic [3:0] cat);
        logic [11:0] rgb_v;
        case (cat)
            CAT_NONE:   rgb_v = RGB_BLACK;
            CAT_WALL:   rgb_v = RGB_WALL;
            CAT_TANK:   rgb_v = RGB_TANK;
            CAT_BULLET: rgb_v = RGB_BULLET;
            default:    rgb_v = RGB_BLACK;
        endcase
        return rgb_v;
    endfunction

endpackage

// File: rtl/vga_scan_renderer_if.sv
// Link between the renderer, the game core (coordinates out, category back)
// and the VGA connector pins.
interface vga_scan_renderer_if;

    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [3:0] category;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       hsync;
    logic       vsync;
    logic       frame_tick;

    modport master (
        output pixel_x, pixel_y, vga_r, vga_g, vga_b, hsync, vsync, frame_tick,
        input  category
    );

    modport slave (
        input  pixel_x, pixel_y, vga_r, vga_g, vga_b, hsync, vsync, frame_tick,
        output category
    );

endinterface

// File: rtl/vga_scan_renderer_timing_gen.sv
// Scan timing: pixel-rate divider, horizontal/vertical counters, registered
// sync pulses and the frame start pulse. Every timing sum must fit in 10 bits
// (total <= 1024) and CLK_DIV must be at least 2 so the game core sees stable
// coordinates for at least one clock before they are sampled.
module vga_scan_renderer_timing_gen
    import vga_scan_renderer_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pix_tick,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [DIV_W-1:0] div_r;
    logic [9:0]       pixel_x_r;
    logic [9:0]       pixel_y_r;
    logic             hsync_r;
    logic             vsync_r;
    logic             frame_tick_r;

    logic pix_tick_s;
    logic active_s;
    logic h_in_sync_s;
    logic v_in_sync_s;
    logic line_end_s;
    logic frame_end_s;

    // Decode of the current (pre-increment) counters used by this edge's updates.
    always_comb begin
        pix_tick_s  = (div_r == DIV_LAST);
        active_s    = (pixel_x_r < H_VIS) && (pixel_y_r < V_VIS);
        h_in_sync_s = (pixel_x_r >= H_SYNC_FIRST) && (pixel_x_r <= H_SYNC_LAST);
        v_in_sync_s = (pixel_y_r >= V_SYNC_FIRST) && (pixel_y_r <= V_SYNC_LAST);
        line_end_s  = (pixel_x_r == H_LAST);
        frame_end_s = line_end_s && (pixel_y_r == V_LAST);
    end

    // Pixel-rate divider: counts 0..CLK_DIV-1 and wraps on pix_tick.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            div_r <= DIV_ZERO;
        end else if (pix_tick_s) begin
            div_r <= DIV_ZERO;
        end else begin
            div_r <= div_r + DIV_ONE;
        end
    end

    // Scan counters advance only on pix_tick so the game core sees clean steps.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            pixel_x_r <= 10'd0;
            pixel_y_r <= 10'd0;
        end else if (pix_tick_s) begin
            if (line_end_s) begin
                pixel_x_r <= 10'd0;
                if (pixel_y_r == V_LAST) begin
                    pixel_y_r <= 10'd0;
                end else begin
                    pixel_y_r <= pixel_y_r + 10'd1;
                end
            end else begin
                pixel_x_r <= pixel_x_r + 10'd1;
                pixel_y_r <= pixel_y_r;
            end
        end else begin
            pixel_x_r <= pixel_x_r;
            pixel_y_r <= pixel_y_r;
        end
    end

    // Sync pulses describe the pixel just sampled, matching the colour register.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
        end else if (pix_tick_s) begin
            hsync_r <= !h_in_sync_s;
            vsync_r <= !v_in_sync_s;
        end else begin
            hsync_r <= hsync_r;
            vsync_r <= vsync_r;
        end
    end

    // Frame pulse rises together with the counters wrapping to (0,0).
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= pix_tick_s && frame_end_s;
        end
    end

    assign pixel_x    = pixel_x_r;
    assign pixel_y    = pixel_y_r;
    assign pix_tick   = pix_tick_s;
    assign active     = active_s;
    assign hsync      = hsync_r;
    assign vsync      = vsync_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: rtl/vga_scan_renderer.sv
// Display stage of the game core: scan timing plus the category-to-colour
// register, which lands in the same clock as the sync registers so RGB and
// sync always describe the same pixel.
module vga_scan_renderer
    import vga_scan_renderer_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic                 clk_100mhz,
    input  logic                 rst,
    vga_scan_renderer_if.master  vga
);

    logic [9:0]  pixel_x_s;
    logic [9:0]  pixel_y_s;
    logic        pix_tick_s;
    logic        active_s;
    logic        hsync_s;
    logic        vsync_s;
    logic        frame_tick_s;
    logic [11:0] rgb_r;

    vga_scan_renderer_timing_gen #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .pixel_x    (pixel_x_s),
        .pixel_y    (pixel_y_s),
        .pix_tick   (pix_tick_s),
        .active     (active_s),
        .hsync      (hsync_s),
        .vsync      (vsync_s),
        .frame_tick (frame_tick_s)
    );

    // Colour register: category is sampled at pix_tick, blanked outside the visible area.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            rgb_r <= RGB_BLACK;
        end else if (pix_tick_s) begin
            rgb_r <= active_s ? category_colour(vga.category) : RGB_BLACK;
        end else begin
            rgb_r <= rgb_r;
        end
    end

    assign vga.pixel_x    = pixel_x_s;
    assign vga.pixel_y    = pixel_y_s;
    assign vga.vga_r      = rgb_r[11:8];
    assign vga.vga_g      = rgb_r[7:4];
    assign vga.vga_b      = rgb_r[3:0];
    assign vga.hsync      = hsync_s;
    assign vga.vsync      = vsync_s;
    assign vga.frame_tick = frame_tick_s;

endmodule
